// File: rtl/rv32_mem_defs_pkg.sv
// ---------------------------------------------------------------------------
// rv32_mem_defs
//   Shared RV32I memory-access definitions: funct3 encodings for loads and
//   stores, LSU state encoding, and decode helpers for illegal/misaligned
//   accesses. Reused by the decode stage and the load/store unit.
// ---------------------------------------------------------------------------
package rv32_mem_defs;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Loads allow 0,1,2,4,5; stores allow 0,1,2 only.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3 > F3_SW;
        end
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == SZ_HALF) && addr_lo[0]) ||
               ((f3[1:0] == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational byte-lane logic for the LSU (little-endian).
//   Ports:
//     addr_i       [1:0]  byte offset within the word
//     funct3_i     [2:0]  RV32I load/store funct3
//     old_word_i   [31:0] word read from memory
//     store_data_i [31:0] store data (low byte/half used for SB/SH)
//     load_data_o  [31:0] selected lane, sign/zero extended
//     store_word_o [31:0] old word with the addressed lane(s) replaced
// ---------------------------------------------------------------------------
module lsu_lane_align
    import rv32_mem_defs::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered case path would infer a latch.
        byte_sel     = old_word_i[{addr_i, 3'b000} +: 8];
        half_sel     = addr_i[1] ? old_word_i[31:16] : old_word_i[15:0];
        load_data_o  = '0;
        store_word_o = old_word_i;

        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data_o = old_word_i;
            F3_LBU:  load_data_o = {24'd0, byte_sel};
            F3_LHU:  load_data_o = {16'd0, half_sel};
            default: load_data_o = '0;
        endcase

        // Store funct3 0/1/2 share encodings with LB/LH/LW.
        case (funct3_i)
            F3_SB:   store_word_o[{addr_i, 3'b000} +: 8] = store_data_i[7:0];
            F3_SH:   store_word_o[{addr_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            F3_SW:   store_word_o = store_data_i;
            default: store_word_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   RV32I memory-stage load/store unit driving a word-wide data memory with
//   no byte enables. Sub-word stores are read-modify-write. One request in
//   flight at a time; misaligned and illegal accesses never touch memory.
//   Parameter:
//     MEM_RD_LATENCY  cycles mem_read is held before mem_rdata is sampled (1..4)
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     req_valid/req_ready             request handshake (accept in IDLE)
//     req_is_store, req_funct3        operation
//     req_addr, req_wdata             byte address, store data
//     resp_valid                      one-cycle completion pulse
//     resp_rdata                      extended load data (0 for stores/errors)
//     resp_misaligned, resp_illegal   error flags, valid with resp_valid
//     mem_read, mem_write             data memory strobes (never both high)
//     mem_addr, mem_wdata, mem_rdata  word-aligned address, write/read data
// ---------------------------------------------------------------------------
module lsu_mem_master
    import rv32_mem_defs::*;
#(
    parameter int unsigned MEM_RD_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] CNT_LAST = 2'(MEM_RD_LATENCY - 1);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;       // word to write in WR
    logic [31:0] rdata_q;      // load result presented in DONE
    logic        misaligned_q;
    logic        illegal_q;
    logic [1:0]  cnt_q;

    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        req_illegal;
    logic        req_misaligned;

    assign req_illegal    = f3_illegal(req_is_store, req_funct3);
    assign req_misaligned = f3_misaligned(req_funct3, req_addr[1:0]);

    lsu_lane_align u_lane_align (
        .addr_i       (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .old_word_i   (mem_rdata),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            wdata_q      <= '0;
            word_q       <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the pre-edge values, independent of order.
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q       <= req_addr;
                        funct3_q     <= req_funct3;
                        is_store_q   <= req_is_store;
                        wdata_q      <= req_wdata;
                        word_q       <= req_wdata;
                        rdata_q      <= '0;
                        cnt_q        <= '0;
                        illegal_q    <= req_illegal;
                        // Illegal wins: a bad funct3 has no meaningful size.
                        misaligned_q <= !req_illegal && req_misaligned;
                        if (req_illegal || req_misaligned) begin
                            state_q <= ST_DONE;
                        end else if (req_is_store && (req_funct3 == F3_SW)) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_q == CNT_LAST) begin
                        if (is_store_q) begin
                            word_q  <= store_word;
                            state_q <= ST_WR;
                        end else begin
                            rdata_q <= load_data;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_WR:   state_q <= ST_DONE;
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; reset drops mem_write at once.
    assign req_ready       = (state_q == ST_IDLE);
    assign mem_read        = (state_q == ST_RD);
    assign mem_write       = (state_q == ST_WR);
    assign mem_addr        = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata       = mem_write ? word_q : '0;
    assign resp_valid      = (state_q == ST_DONE);
    assign resp_rdata      = resp_valid ? rdata_q : '0;
    assign resp_misaligned = resp_valid && misaligned_q;
    assign resp_illegal    = resp_valid && illegal_q;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit for the RV32I memory stage; drives the word-wide data_memory port (mem_read, mem_write, addr, write_data, read_data) from the initiator side.
- Accepts one load/store request at a time over a valid/ready handshake.
- Handles byte/half/word selection and sign/zero extension; does sub-word stores as read-modify-write, since data_memory has no byte enables.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- MEM_RD_LATENCY, 1, number of cycles mem_read is held before read_data is sampled; 1 = combinational-read memory, 2 = registered-read; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid
- resp_illegal  out  1  valid with resp_valid
- mem_read  out  1  to data_memory
- mem_write  out  1  to data_memory
- mem_addr  out  32  word-aligned: {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  data_memory read_data

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - mem_write drops immediately, so an in-flight RMW never writes.
- All mem_* and resp_* outputs are decoded from registered state and data; there is no combinational path from req_* to any output.
- mem_read and mem_write are never high together.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - req_ready=1; a request is accepted on the clock edge where req_valid=1.
  - Accept registers addr, funct3, is_store and wdata.
  - Illegal funct3 (loads 3/6/7, stores 3..7) goes to DONE with resp_illegal=1.
  - Misaligned access goes to DONE with resp_misaligned=1. Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal takes priority over misaligned.
  - Loads and SB/SH go to RD; SW goes to WR.
- RD:
  - mem_read=1 and mem_addr stable for exactly MEM_RD_LATENCY cycles, counted by a 2-bit counter.
  - mem_rdata is captured on the edge ending the last RD cycle.
  - Load goes to DONE with the extracted, extended result.
  - SB/SH goes to WR with the merged word.
- Lane rules (little-endian; byte k = bits 8k+7:8k):
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Store merge replaces only the addressed byte/half with req_wdata[7:0] or [15:0]; other lanes keep the old word.
- WR: one cycle, mem_write=1, mem_wdata = merged word (SW: req_wdata); then DONE.
- DONE: resp_valid=1 for exactly one cycle, req_ready=0; then IDLE.
- Latency from the accept edge to resp_valid:
  - load: MEM_RD_LATENCY+1
  - SW: 2
  - SB/SH: MEM_RD_LATENCY+2
  - error: 1
- req_valid is ignored outside IDLE; the requester must hold the request until req_ready.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE; there is no bypass.
- Error and idle cycles drive mem_addr=0 and mem_wdata=0.

Decomposition:
- Shared package/include rv32_mem_defs: funct3 localparams (F3_LB..F3_LHU, F3_SB..F3_SW) and LSU state encodings, reused by the decode stage.
- One combinational sub-module, lsu_lane_align: inputs are addr[1:0], funct3, old word and store data; outputs are the extended load value and the merged store word. It is unit-testable on its own.
- The FSM, latency counter and registers stay in lsu_mem_master.

Test Plan:
- SW addr 0x0, wdata 0xCAFEBABE -> exactly one mem_write cycle with mem_wdata=0xCAFEBABE, no mem_read; resp_valid 2 cycles after accept; resp_rdata=0.
- Then loads from word 0xCAFEBABE:
  - LB 0x1 -> 0xFFFFFFBA
  - LBU 0x3 -> 0x000000CA
  - LH 0x2 -> 0xFFFFCAFE
  - LHU 0x0 -> 0x0000BABE
  - LW 0x0 -> 0xCAFEBABE
  - resp_valid at accept+2 each.
- SB 0x2, wdata 0x00000055 -> one mem_read cycle, then mem_write with mem_wdata=0xCA55BABE; a following LW 0x0 returns 0xCA55BABE; resp at accept+3.
- LW 0x6 and SH 0x3 -> resp_misaligned=1 at accept+1, with no mem_read or mem_write ever asserted. Load funct3=3 -> resp_illegal=1, resp_misaligned=0.
- Reset during the RD cycle of SH 0x0 -> mem_read falls immediately, no mem_write ever, req_ready=1; a later LW 0x0 returns the unchanged word.
- MEM_RD_LATENCY=2 build: LW -> mem_read high 2 cycles, resp at accept+3; req_valid pulsed while busy is ignored (no second access).
